// File: rtl/ctrl_types_pkg.sv
// Shared controller types: sub-FSM states, sub-FSM response and delete error codes.
// Ports: none (package only).
// Imported by the controller and its GET/SET/PUT/DEL sub-FSMs.
package ctrl_types_pkg;

  // Delete sub-FSM states. The mixed DEL_ST_/ST_DEL_ prefixes are historical
  // and referenced by the top controller, so they are kept as-is.
  typedef enum logic [2:0] {
    DEL_ST_START        = 3'd0,
    DEL_ST_CHECK_EXISTS = 3'd1,
    ST_DEL_DELETE       = 3'd2,
    ST_DEL_DONE         = 3'd3,
    ST_DEL_ERROR        = 3'd4
  } del_substate_e;

  // One-cycle response pulses from any sub-FSM back to the top controller.
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  // Cause of the most recent delete failure.
  typedef enum logic [1:0] {
    DEL_ERR_NONE      = 2'd0,
    DEL_ERR_NOT_FOUND = 2'd1,
    DEL_ERR_TIMEOUT   = 2'd2
  } del_err_e;

endpackage

// File: rtl/ctrl_del_fsm_if.sv
// Key-store / valid-bit array handshake used by the delete sub-FSM.
// Ports: lookup_req_o/lookup_key_o -> lookup_ack_i/lookup_hit_i/lookup_idx_i;
//        del_req_o/del_idx_o -> del_ack_i. master = FSM side, slave = key store.
interface ctrl_del_fsm_if #(
  parameter int KEY_WIDTH = 16,
  parameter int IDX_WIDTH = 4
);
  logic                 lookup_req_o;
  logic [KEY_WIDTH-1:0] lookup_key_o;
  logic                 lookup_ack_i;
  logic                 lookup_hit_i;
  logic [IDX_WIDTH-1:0] lookup_idx_i;
  logic                 del_req_o;
  logic [IDX_WIDTH-1:0] del_idx_o;
  logic                 del_ack_i;

  modport master (
    output lookup_req_o, lookup_key_o, del_req_o, del_idx_o,
    input  lookup_ack_i, lookup_hit_i, lookup_idx_i, del_ack_i
  );

  modport slave (
    input  lookup_req_o, lookup_key_o, del_req_o, del_idx_o,
    output lookup_ack_i, lookup_hit_i, lookup_idx_i, del_ack_i
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Saturating ack-wait counter shared by the controller sub-FSMs.
// Latency: expired is registered-count decode, high once TIMEOUT_CYCLES-1 cycles of run have elapsed.
// Backpressure: none; clear wins over run. Ports: clk, rst, clear, run -> expired.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturate at LAST so a caller that keeps run high never sees a wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/ctrl_del_fsm.sv
// Delete responder: lookup key, invalidate hit entry, pulse done/error to the controller.
// Latency: start at edge N -> lookup_req N+1, del_req N+2, done N+3 (same-cycle acks); miss error N+2.
// Backpressure: requests hold until acked, timed out, aborted or reset; start ignored while busy.
// Ports: clk, rst; start_i/abort_i/key_i from controller; sub_cmd_o/err_code_o/busy_o/state_o back;
//        ks (master) carries the key-store lookup and invalidate handshakes.
module ctrl_del_fsm
  import ctrl_types_pkg::*;
#(
  parameter int KEY_WIDTH      = 16,
  parameter int NUM_ENTRIES    = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output sub_cmd_t             sub_cmd_o,
  output del_err_e             err_code_o,
  output logic                 busy_o,
  output del_substate_e        state_o,
  ctrl_del_fsm_if.master       ks
);
  localparam int IDX_WIDTH = $clog2(NUM_ENTRIES);

  del_substate_e        state;
  logic [KEY_WIDTH-1:0] key_q;
  logic [IDX_WIDTH-1:0] idx_q;
  del_err_e             err_q;

  logic in_lookup;
  logic in_delete;
  logic tmr_clear;
  logic tmr_run;
  logic tmr_expired;

  assign in_lookup = (state == DEL_ST_CHECK_EXISTS);
  assign in_delete = (state == ST_DEL_DELETE);

  // The counter is held cleared outside the wait states, and also on the
  // lookup-ack cycle so that DELETE starts with a fresh window.
  assign tmr_clear = !(in_lookup || in_delete) || (in_lookup && ks.lookup_ack_i);
  assign tmr_run   = (in_lookup && !ks.lookup_ack_i) || (in_delete && !ks.del_ack_i);

  ctrl_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  // Abort is checked ahead of the case so it beats start, acks and timeout,
  // and it touches nothing but the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEL_ST_START;
      key_q <= '0;
      idx_q <= '0;
      err_q <= DEL_ERR_NONE;
    end else if (abort_i) begin
      state <= DEL_ST_START;
    end else begin
      unique case (state)
        DEL_ST_START: begin
          if (start_i) begin
            key_q <= key_i;
            err_q <= DEL_ERR_NONE;
            state <= DEL_ST_CHECK_EXISTS;
          end
        end
        DEL_ST_CHECK_EXISTS: begin
          // An ack in the last window cycle is taken before the timeout.
          if (ks.lookup_ack_i) begin
            if (ks.lookup_hit_i) begin
              idx_q <= ks.lookup_idx_i;
              state <= ST_DEL_DELETE;
            end else begin
              err_q <= DEL_ERR_NOT_FOUND;
              state <= ST_DEL_ERROR;
            end
          end else if (tmr_expired) begin
            err_q <= DEL_ERR_TIMEOUT;
            state <= ST_DEL_ERROR;
          end
        end
        ST_DEL_DELETE: begin
          if (ks.del_ack_i) begin
            state <= ST_DEL_DONE;
          end else if (tmr_expired) begin
            err_q <= DEL_ERR_TIMEOUT;
            state <= ST_DEL_ERROR;
          end
        end
        ST_DEL_DONE:  state <= DEL_ST_START;
        ST_DEL_ERROR: state <= DEL_ST_START;
        default:      state <= DEL_ST_START;
      endcase
    end
  end

  // Every output is a decode of the state register or a captured register.
  assign sub_cmd_o.done  = (state == ST_DEL_DONE);
  assign sub_cmd_o.error = (state == ST_DEL_ERROR);
  assign err_code_o      = err_q;
  assign busy_o          = (state != DEL_ST_START);
  assign state_o         = state;
  assign ks.lookup_req_o = in_lookup;
  assign ks.lookup_key_o = key_q;
  assign ks.del_req_o    = in_delete;
  assign ks.del_idx_o    = idx_q;
endmodule
